// File: rtl/beta_trap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : beta_trap_pkg
// Purpose  : Shared encodings for the Beta trap sequencer (PC mux codes,
//            cause codes, FSM states, vector offsets).
// Revision : 1.0  initial release
// ============================================================================
package beta_trap_pkg;

    localparam logic [1:0]  PC_NEXT       = 2'b00;
    localparam logic [1:0]  PC_IRQ        = 2'b01;
    localparam logic [1:0]  PC_ILLOP      = 2'b10;

    localparam logic [4:0]  CAUSE_ILLOP   = 5'd0;

    localparam logic [31:0] VEC_OFS_ILLOP = 32'd4;
    localparam logic [31:0] VEC_OFS_IRQ   = 32'd8;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        SUPV = 1'b1
    } trap_state_e;

endpackage
`default_nettype wire

// File: rtl/beta_irq_sync.sv
`default_nettype none
// ============================================================================
// Module   : beta_irq_sync
// Purpose  : Per-channel multi-stage synchroniser with rising-edge detect.
// Revision : 1.0  initial release
// ============================================================================
module beta_irq_sync #(
    parameter int NIRQ        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq,
    output logic [NIRQ-1:0] s_irq,
    output logic [NIRQ-1:0] rise
);

    // Stage 0 takes the raw input; stage SYNC_STAGES-1 is the safe copy.
    logic [SYNC_STAGES-1:0][NIRQ-1:0] sync_q;
    logic [SYNC_STAGES-1:0][NIRQ-1:0] sync_d;
    logic [NIRQ-1:0]                  prev_q;
    logic [NIRQ-1:0]                  prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign s_irq = sync_q[SYNC_STAGES-1];
    assign rise  = s_irq & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/beta_trap_ctl.sv
`default_nettype none
// ============================================================================
// Module   : beta_trap_ctl
// Purpose  : Exception/interrupt sequencer for the Beta core: prioritises
//            illop and masked irq channels, drives PC mux, vector and XP write.
// Revision : 1.0  initial release
// ============================================================================
module beta_trap_ctl
    import beta_trap_pkg::*;
#(
    parameter int              NIRQ        = 4,
    parameter logic [31:0]     VEC_BASE    = 32'h8000_0000,
    parameter logic [NIRQ-1:0] EDGE_MASK   = {NIRQ{1'b1}},
    parameter logic [NIRQ-1:0] MASK_RST    = {NIRQ{1'b0}},
    parameter int              SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq,
    input  logic            sup,
    input  logic            illop,
    input  logic            mask_we,
    input  logic [NIRQ-1:0] mask_wdata,
    output logic [1:0]      pc_ctl,
    output logic [31:0]     trap_vec,
    output logic            xp_we,
    output logic [NIRQ-1:0] irq_ack,
    output logic [NIRQ-1:0] pending,
    output logic [NIRQ-1:0] mask,
    output logic [4:0]      xcause
);

    logic [NIRQ-1:0] s_irq;
    logic [NIRQ-1:0] rise;
    logic [NIRQ-1:0] eligible;
    logic [NIRQ-1:0] onehot;
    logic [4:0]      sel;
    logic            found;
    logic            trap;

    logic [NIRQ-1:0] pend_q,     pend_d;
    logic [NIRQ-1:0] mask_q,     mask_d;
    logic [4:0]      xcause_q,   xcause_d;
    logic            sup_prev_q, sup_prev_d;
    trap_state_e     state_q,    state_d;

    beta_irq_sync #(
        .NIRQ        (NIRQ),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .irq   (irq),
        .s_irq (s_irq),
        .rise  (rise)
    );

    // Level channels bypass the latch entirely; their pend_q bits stay zero.
    assign pending  = (pend_q & EDGE_MASK) | (s_irq & ~EDGE_MASK);
    assign eligible = pending & ~mask_q;
    assign mask     = mask_q;
    assign xcause   = xcause_q;

    always_comb begin
        found  = 1'b0;
        sel    = '0;
        onehot = '0;
        for (int k = 0; k < NIRQ; k++) begin
            if (eligible[k] && !found) begin
                found     = 1'b1;
                sel       = 5'(k);
                onehot[k] = 1'b1;
            end
        end
    end

    always_comb begin
        pc_ctl     = PC_NEXT;
        trap_vec   = VEC_BASE;
        xp_we      = 1'b0;
        irq_ack    = '0;
        trap       = 1'b0;
        xcause_d   = xcause_q;
        mask_d     = mask_we ? mask_wdata : mask_q;
        sup_prev_d = sup;
        state_d    = state_q;

        // Outputs are forced idle while reset is held, even if illop is set.
        if (reset) begin
            if (illop) begin
                pc_ctl   = PC_ILLOP;
                trap_vec = VEC_BASE + VEC_OFS_ILLOP;
                xp_we    = 1'b1;
                trap     = 1'b1;
                xcause_d = CAUSE_ILLOP;
            end else if ((state_q == RUN) && !sup && found) begin
                pc_ctl   = PC_IRQ;
                trap_vec = VEC_BASE + VEC_OFS_IRQ + {25'd0, sel, 2'b00};
                xp_we    = 1'b1;
                irq_ack  = onehot;
                trap     = 1'b1;
                xcause_d = sel + 5'd1;
            end
        end

        pend_d = ((pend_q & ~irq_ack) | rise) & EDGE_MASK;

        // SUPV holds off irqs until the kernel return drops ia[31].
        case (state_q)
            RUN:     if (trap) state_d = SUPV;
            SUPV:    if (!trap && !sup && sup_prev_q) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q     <= '0;
            mask_q     <= MASK_RST;
            xcause_q   <= CAUSE_ILLOP;
            sup_prev_q <= 1'b0;
            state_q    <= RUN;
        end else begin
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            xcause_q   <= xcause_d;
            sup_prev_q <= sup_prev_d;
            state_q    <= state_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_beta_trap_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_beta_trap_ctl
// Purpose  : Directed plus random bench for beta_trap_ctl against a
//            cycle-level behavioural model of the trap rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_beta_trap_ctl;

    localparam int          NIRQ = 4;
    localparam int          SYNC = 2;
    localparam logic [31:0] VB   = 32'h8000_0000;
    localparam logic [3:0]  EDGE = 4'b1101;   // channel 1 is level-sensitive

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  irq = '0;
    logic        sup = 1'b0;
    logic        illop = 1'b0;
    logic        mask_we = 1'b0;
    logic [3:0]  mask_wdata = '0;
    logic [1:0]  pc_ctl;
    logic [31:0] trap_vec;
    logic        xp_we;
    logic [3:0]  irq_ack;
    logic [3:0]  pending;
    logic [3:0]  mask;
    logic [4:0]  xcause;

    beta_trap_ctl #(
        .NIRQ        (NIRQ),
        .VEC_BASE    (VB),
        .EDGE_MASK   (EDGE),
        .MASK_RST    (4'b0000),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .sup        (sup),
        .illop      (illop),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .pc_ctl     (pc_ctl),
        .trap_vec   (trap_vec),
        .xp_we      (xp_we),
        .irq_ack    (irq_ack),
        .pending    (pending),
        .mask       (mask),
        .xcause     (xcause)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state
    logic [3:0]  m_pend, m_mask;
    logic [4:0]  m_xcause;
    bit          m_kernel, m_sup_prev;
    logic [3:0]  m_hist[$];   // m_hist[0] = irq sampled on the latest edge

    // Model expectations for the current cycle
    logic [1:0]  e_pc;
    logic [31:0] e_vec;
    logic        e_we, e_take;
    logic [3:0]  e_ack, e_pending;
    logic [4:0]  e_cause;

    // Last observed DUT outputs
    logic [1:0]  o_pc;
    logic [31:0] o_vec;
    logic [3:0]  o_ack, o_pend;
    logic [4:0]  o_xc;
    int          n_taken;

    logic [3:0]  cur_irq, r_mwd;
    logic        cur_sup, r_ill, r_mwe;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_pend = '0; m_mask = '0; m_xcause = '0; m_kernel = 0; m_sup_prev = 0;
        m_hist = {};
        for (int i = 0; i <= SYNC; i++) m_hist.push_back(4'b0);
    endfunction

    function automatic void model_eval();
        logic [3:0] s, elig;
        int kk;
        s         = m_hist[SYNC-1];
        e_pending = (m_pend & EDGE) | (s & ~EDGE);
        elig      = e_pending & ~m_mask;
        e_pc = 2'b00; e_vec = VB; e_we = 0; e_ack = '0; e_take = 0; e_cause = m_xcause;
        if (reset) begin
            if (illop) begin
                e_pc = 2'b10; e_vec = VB + 32'd4; e_we = 1; e_take = 1; e_cause = 5'd0;
            end else if (!m_kernel && !sup && elig != 0) begin
                kk = 0;
                for (int k = NIRQ - 1; k >= 0; k--) if (elig[k]) kk = k;
                e_pc = 2'b01; e_vec = VB + 32'd8 + 32'(4 * kk); e_we = 1;
                e_ack = 4'(1 << kk); e_take = 1; e_cause = 5'(kk + 1);
            end
        end
    endfunction

    function automatic void model_commit();
        logic [3:0] rise;
        rise   = m_hist[SYNC-1] & ~m_hist[SYNC];
        m_pend = ((m_pend & ~e_ack) | rise) & EDGE;
        if (mask_we) m_mask = mask_wdata;
        if (e_take) begin
            m_xcause = e_cause;
            m_kernel = 1;
        end else if (m_kernel && !sup && m_sup_prev) begin
            m_kernel = 0;
        end
        m_sup_prev = sup;
        m_hist.push_front(irq);
        void'(m_hist.pop_back());
    endfunction

    task automatic check_outputs();
        chk($sformatf("c%0d pc_ctl", cyc),   32'(pc_ctl),   32'(e_pc));
        chk($sformatf("c%0d trap_vec", cyc), trap_vec,      e_vec);
        chk($sformatf("c%0d xp_we", cyc),    32'(xp_we),    32'(e_we));
        chk($sformatf("c%0d irq_ack", cyc),  32'(irq_ack),  32'(e_ack));
        chk($sformatf("c%0d pending", cyc),  32'(pending),  32'(e_pending));
        chk($sformatf("c%0d mask", cyc),     32'(mask),     32'(m_mask));
        chk($sformatf("c%0d xcause", cyc),   32'(xcause),   32'(m_xcause));
        o_pc = pc_ctl; o_vec = trap_vec; o_ack = irq_ack; o_pend = pending; o_xc = xcause;
        if (pc_ctl != 2'b00) n_taken++;
    endtask

    task automatic cycle(input logic [3:0] i_irq, input logic i_sup, input logic i_illop,
                         input logic i_mwe = 1'b0, input logic [3:0] i_mwd = 4'b0);
        @(negedge clk);
        irq = i_irq; sup = i_sup; illop = i_illop; mask_we = i_mwe; mask_wdata = i_mwd;
        #1;
        model_eval();
        check_outputs();
        model_commit();
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        model_eval();
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        do_reset();
        chk("rst_pc", 32'(o_pc), 32'd0);
        chk("rst_vec", o_vec, 32'h8000_0000);

        // Edge pulse on channel 2: trap three cycles later
        cycle(4'b0100, 0, 0);
        cycle(4'b0000, 0, 0);
        cycle(4'b0000, 0, 0);
        cycle(4'b0000, 0, 0);
        chk("t1_pc", 32'(o_pc), 32'd1);
        chk("t1_vec", o_vec, 32'h8000_0010);
        chk("t1_ack", 32'(o_ack), 32'b0100);
        cycle(4'b0000, 0, 0);
        chk("t1_xcause", 32'(o_xc), 32'd3);
        chk("t1_pend_clr", 32'(o_pend), 32'd0);
        cycle(4'b0000, 1, 0);
        cycle(4'b0000, 0, 0);

        // Channels 0 and 3 together: one per entry, in index order
        cycle(4'b1001, 0, 0);
        cycle(4'b1001, 0, 0);
        cycle(4'b1001, 0, 0);
        cycle(4'b1001, 0, 0);
        chk("t2_vec_a", o_vec, 32'h8000_0008);
        n_taken = 0;
        repeat (5) cycle(4'b1001, 1, 0);
        chk("t2_held_off", 32'(n_taken), 32'd0);
        cycle(4'b1001, 0, 0);
        cycle(4'b1001, 0, 0);
        chk("t2_vec_b", o_vec, 32'h8000_0014);
        cycle(4'b0000, 0, 0);
        chk("t2_xcause", 32'(o_xc), 32'd4);
        cycle(4'b0000, 1, 0);
        cycle(4'b0000, 0, 0);

        // Illop beats a pending level irq
        cycle(4'b0010, 1, 0);
        cycle(4'b0010, 1, 0);
        cycle(4'b0010, 0, 1);
        chk("t3_pc", 32'(o_pc), 32'd2);
        chk("t3_vec", o_vec, 32'h8000_0004);
        chk("t3_ack", 32'(o_ack), 32'd0);
        chk("t3_pend1", 32'(o_pend[1]), 32'd1);
        cycle(4'b0010, 0, 0);
        chk("t3_xcause", 32'(o_xc), 32'd0);
        cycle(4'b0000, 1, 0);
        cycle(4'b0000, 1, 0);
        cycle(4'b0000, 1, 0);
        cycle(4'b0000, 0, 0);

        // Masked channel stays pending; unmask releases it
        cycle(4'b0000, 0, 0, 1, 4'b0010);
        n_taken = 0;
        repeat (4) cycle(4'b0010, 0, 0);
        chk("t4_masked_pend", 32'(o_pend), 32'b0010);
        cycle(4'b0010, 0, 0, 1, 4'b0000);
        chk("t4_no_trap", 32'(n_taken), 32'd0);
        cycle(4'b0010, 0, 0);
        chk("t4_vec", o_vec, 32'h8000_000C);

        // Level channel still high after return traps again, then drops
        cycle(4'b0010, 1, 0);
        cycle(4'b0010, 0, 0);
        cycle(4'b0010, 0, 0);
        chk("t5_retrap", o_vec, 32'h8000_000C);
        chk("t5_pc", 32'(o_pc), 32'd1);
        cycle(4'b0000, 1, 0);
        cycle(4'b0000, 1, 0);
        cycle(4'b0000, 1, 0);
        chk("t5_pend_drop", 32'(o_pend), 32'd0);
        cycle(4'b0000, 0, 0);

        // Reset while in SUPV with channel 3 pending
        cycle(4'b0001, 0, 0);
        cycle(4'b0000, 0, 0);
        cycle(4'b0000, 0, 0);
        cycle(4'b0000, 0, 0);
        cycle(4'b1000, 0, 0);
        cycle(4'b1000, 0, 0);
        cycle(4'b1000, 0, 0);
        cycle(4'b0000, 0, 0);
        chk("t6_pend_pre", 32'(o_pend), 32'b1000);
        chk("t6_xc_pre", 32'(o_xc), 32'd1);
        do_reset();
        chk("t6_pend_rst", 32'(o_pend), 32'd0);
        chk("t6_pc_rst", 32'(o_pc), 32'd0);
        chk("t6_xc_rst", 32'(o_xc), 32'd0);
        n_taken = 0;
        repeat (8) cycle(4'b0000, 0, 0);
        chk("t6_no_trap", 32'(n_taken), 32'd0);

        // Randomised traffic against the model
        cur_irq = '0;
        cur_sup = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            for (int b = 0; b < NIRQ; b++)
                if ($urandom_range(7) == 0) cur_irq[b] = ~cur_irq[b];
            if ($urandom_range(5) == 0) cur_sup = ~cur_sup;
            r_ill = ($urandom_range(39) == 0);
            r_mwe = ($urandom_range(29) == 0);
            r_mwd = 4'($urandom);
            if (n == 700) do_reset();
            cycle(cur_irq, cur_sup, r_ill, r_mwe, r_mwd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/beta_trap_ctl.md
Name: beta_trap_ctl

Overview:
- Parametrised exception/interrupt sequencer for the Beta core; successor to the single-input irq/illop PC-control logic.
- Accepts NIRQ asynchronous interrupt lines, each edge- or level-sensitive, with a software mask, pending latches and fixed priority.
- Drives the PC-select code and trap vector into the PC mux, tags cause, and requests the XP write of PC+4.
- Sits between the control decoder (illop), the PC register (ia[31] supervisor bit) and the regfile write port.

Parameters:
- NIRQ, 4: number of interrupt channels, 1..16.
- VEC_BASE, 32'h80000000: reset vector; illop vector = VEC_BASE+4; irq channel k vector = VEC_BASE+8+4*k.
- EDGE_MASK, all-ones (NIRQ bits): bit k=1 makes channel k rising-edge latched; 0 makes it level.
- MASK_RST, 0 (NIRQ bits): reset value of the mask register; 1 = masked.
- SYNC_STAGES, 2: synchroniser depth on irq inputs, ≥2.

Ports:
- clk, in, 1: core clock.
- reset, in, 1: asynchronous, active-low reset.
- irq, in, NIRQ: asynchronous interrupt requests.
- sup, in, 1: current supervisor bit (ia[31]).
- illop, in, 1: illegal-opcode flag from decoder, current instruction.
- mask_we, in, 1: load mask register.
- mask_wdata, in, NIRQ: new mask value.
- pc_ctl, out, 2: 00 next-PC, 01 irq vector, 10 illop vector (PC mux encoding).
- trap_vec, out, 32: vector address, valid when pc_ctl≠00.
- xp_we, out, 1: write PC+4 into XP this cycle.
- irq_ack, out, NIRQ: one-hot, channel taken this cycle.
- pending, out, NIRQ: pending register (level channels show synced level).
- mask, out, NIRQ: mask register.
- xcause, out, 5: cause of last trap; 0 = illop, k+1 = irq channel k.

Behaviour:
- Reset (reset=0, async): synchroniser flops 0, edge history 0, pending 0, mask=MASK_RST, xcause 0, state RUN. Outputs pc_ctl=00, trap_vec=VEC_BASE, xp_we=0, irq_ack=0. Release is synchronous to clk via normal flop sampling.
- Sync: irq passes SYNC_STAGES flops → s_irq. Input-to-pending latency is SYNC_STAGES+1 cycles for edge channels and SYNC_STAGES for level channels.
- Edge channel k: pending[k] sets when s_irq[k]=1 and previous s_irq[k]=0. It clears on the clock after irq_ack[k]. Set and ack on the same edge: set wins.
- Level channel k: pending[k]=s_irq[k]; there is no latch and ack has no storage effect.
- eligible = pending & ~mask. Masking never clears pending.
- mask_we writes the mask on the next edge. The new mask applies from the following cycle.
- Decision logic is combinational, in the same cycle as the instruction (single-cycle core):
  - illop=1 (any sup): pc_ctl=10, trap_vec=VEC_BASE+4, xp_we=1, xcause←0. Illop beats all irqs.
  - Else if state RUN and sup=0 and eligible≠0: take the lowest set index k. pc_ctl=01, trap_vec=VEC_BASE+8+4k, irq_ack[k]=1, xp_we=1, xcause←k+1.
  - Else pc_ctl=00, xp_we=0.
- FSM:
  - RUN: taking a trap → SUPV.
  - SUPV: no irq taken regardless of sup; illop still traps. Transition SUPV→RUN on the cycle sup is sampled 0 after having been 1 (kernel return).
  - A trap taken in SUPV stays in SUPV.
  - This blocks re-entry in the cycle before ia[31] becomes visible.
- sup=1 in RUN (e.g., after reset at VEC_BASE): irqs held off, pending retained.
- Simultaneous eligible edges on several channels: one taken per entry; the rest stay pending and are taken on later returns in index order.
- Reset mid-trap: all state cleared, pending lost, FSM RUN.

Decomposition:
- Package beta_trap_pkg holds:
  - pc_ctl encodings PC_NEXT=2'b00, PC_IRQ=2'b01, PC_ILLOP=2'b10;
  - cause code CAUSE_ILLOP=0;
  - FSM enum {RUN, SUPV};
  - vector offset constants 4 and 8.
- Sub-module beta_irq_sync: SYNC_STAGES-deep per-channel synchroniser plus edge detector, outputs s_irq and rise.
- Priority encode, FSM and mask/cause registers stay in beta_trap_ctl.

Test Plan:
- Reset with sup=0, pulse irq[2] (edge) for 1 cycle, mask=0 → after 3 cycles pc_ctl=01, trap_vec=0x80000010, irq_ack=4'b0100, xp_we=1, xcause=3; next cycle pending[2]=0, state SUPV.
- irq[0] and irq[3] rise in the same cycle, sup=0 → first entry vec 0x80000008 xcause=1. Hold sup=1 5 cycles → no trap. Drop sup=0 → second entry vec 0x80000014 xcause=4.
- illop=1 while pending[1]=1, sup=0 → pc_ctl=10, trap_vec=0x80000004, irq_ack=0, xcause=0; pending[1] still 1.
- mask_wdata=4'b0010, irq[1] pulse → pending[1]=1, no trap. Then write mask=0 → trap to 0x8000000C two cycles after the write.
- Level channel (EDGE_MASK bit1=0): hold irq[1]=1 → trap to 0x8000000C; after return with irq still high, it traps again. Deassert irq → pending[1]=0 after 2 cycles.
- Assert reset low mid-SUPV with pending=4'b1000 → pending=0, pc_ctl=00, xcause=0 immediately; after release, no trap without a new irq edge.
